// File: rtl/flip_read_decoder.sv
// Read-side flip decoder: issues a single storage read, captures the data word and its
// per-segment flip flags, un-inverts flagged segments and hands the word out on valid/ready.
module flip_read_decoder #(
    parameter int N       = 16,
    parameter int FLIP_W  = 4,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_rdata,
    input  logic [FLIP_W-1:0] mem_flip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [FLIP_W-1:0] out_flip,
    output logic [CNT_W-1:0]  flip_cnt
);
    localparam int SW = N / FLIP_W;
    localparam int LW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                       state, state_nx;
    logic [LW-1:0]                lat_cnt;
    logic [FLIP_W-1:0][SW-1:0]    seg_in, seg_out;
    logic                         capture, hs;

    assign seg_in = mem_rdata;

    // each segment is restored independently by its own flag
    for (genvar g = 0; g < FLIP_W; g++) begin : g_seg
        assign seg_out[g] = seg_in[g] ^ {SW{mem_flip[g]}};
    end

    assign req_ready = (state == IDLE);
    assign capture   = (state == WAIT) && (lat_cnt == LW'(1));
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (capture) state_nx = HOLD;
            HOLD:    if (hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flip  <= '0;
            flip_cnt  <= '0;
        end else begin
            state     <= state_nx;
            // strobe is high during the ISSUE cycle only
            mem_rd_en <= (state == IDLE) && req_valid;
            if ((state == IDLE) && req_valid)
                mem_addr <= req_addr;
            if (state == ISSUE)
                lat_cnt <= LW'(MEM_LAT);
            else if (state == WAIT)
                lat_cnt <= lat_cnt - LW'(1);
            if (capture) begin
                out_data  <= seg_out;
                out_flip  <= mem_flip;
                out_valid <= 1'b1;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
            if (hs && (|out_flip) && (flip_cnt != {CNT_W{1'b1}}))
                flip_cnt <= flip_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_flip_read_decoder.sv
// Bench for flip_read_decoder: two instances (MEM_LAT=1/CNT_W=16 and MEM_LAT=3/CNT_W=2)
// checked every cycle against a transaction-timeline model, plus directed literal checks.
module tb_flip_read_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, out_ready;
    logic [7:0]  req_addr;
    logic        rdy[2], rd_en[2], ov[2];
    logic [7:0]  maddr[2];
    logic [15:0] mrd[2], od[2];
    logic [3:0]  mfl[2], of[2];
    logic [15:0] fc0;
    logic [1:0]  fc1;

    int tests = 0, fails = 0, cyc = 0;
    bit chk_en = 0, rec_en = 0, pend = 0;

    // model: per instance, the timeline of the single outstanding transaction
    int          lat[2]  = '{1, 3};
    int          cmax[2] = '{65535, 3};
    bit          busy[2];
    int          acc[2], ecnt[2];
    logic [7:0]  eaddr[2];
    logic [15:0] edata[2], w[2];
    logic [3:0]  eflip[2], f[2];
    bit          dir_en;
    logic [15:0] dir_w;
    logic [3:0]  dir_f;
    int          accq[$], cntq[$];
    int          sat_exp[5] = '{1, 2, 3, 3, 3};

    flip_read_decoder #(.N(16), .FLIP_W(4), .ADDR_W(8), .MEM_LAT(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
        .mem_rd_en(rd_en[0]), .mem_addr(maddr[0]), .mem_rdata(mrd[0]), .mem_flip(mfl[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_flip(of[0]),
        .flip_cnt(fc0));

    flip_read_decoder #(.N(16), .FLIP_W(4), .ADDR_W(8), .MEM_LAT(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
        .mem_rd_en(rd_en[1]), .mem_addr(maddr[1]), .mem_rdata(mrd[1]), .mem_flip(mfl[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_flip(of[1]),
        .flip_cnt(fc1));

    function automatic logic [15:0] dec(input logic [15:0] d, input logic [3:0] fl);
        logic [15:0] r;
        r = d;
        for (int s = 0; s < 4; s++)
            if (fl[s]) r = r ^ (16'hF << (4 * s));
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // storage: the planned word appears only in the capture cycle, garbage otherwise
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (busy[k] && cyc == acc[k] + 1 + lat[k]) begin
                mrd[k] = w[k];
                mfl[k] = f[k];
            end else begin
                mrd[k] = 16'($urandom);
                mfl[k] = 4'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (chk_en) begin
                chk("req_ready", k, rdy[k], !busy[k]);
                chk("mem_rd_en", k, rd_en[k], busy[k] && cyc == acc[k] + 1);
                chk("mem_addr", k, maddr[k], eaddr[k]);
                chk("out_valid", k, ov[k], busy[k] && cyc >= acc[k] + 2 + lat[k]);
                chk("out_data", k, od[k], edata[k]);
                chk("out_flip", k, of[k], eflip[k]);
                chk("flip_cnt", k, (k == 0) ? 32'(fc0) : 32'(fc1), ecnt[k]);
            end
        end
        if (rec_en) begin
            if (pend) begin
                cntq.push_back(int'(fc1));
                pend = 0;
            end
            if (ov[1] && out_ready && !rst) pend = 1;
            if (rdy[1] && req_valid && !rst) accq.push_back(cyc);
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] = 0; eaddr[k] = '0; edata[k] = '0; eflip[k] = '0; ecnt[k] = 0;
            end else if (!busy[k]) begin
                if (req_valid) begin
                    busy[k] = 1; acc[k] = cyc; eaddr[k] = req_addr;
                    w[k] = dir_en ? dir_w : 16'($urandom);
                    f[k] = dir_en ? dir_f : 4'($urandom);
                end
            end else if (cyc == acc[k] + 1 + lat[k]) begin
                edata[k] = dec(w[k], f[k]);
                eflip[k] = f[k];
            end else if (cyc >= acc[k] + 2 + lat[k] && out_ready) begin
                busy[k] = 0;
                if (eflip[k] != 0 && ecnt[k] < cmax[k]) ecnt[k]++;
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; acc[k] = 0; ecnt[k] = 0; eaddr[k] = '0; edata[k] = '0;
            eflip[k] = '0; w[k] = '0; f[k] = '0; mrd[k] = '0; mfl[k] = '0;
        end
        rst = 1; dir_en = 0; dir_w = '0; dir_f = '0;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'($urandom); out_ready = 1'($urandom); req_addr = 8'($urandom);
            tick();
            chk_en = 1;
        end
        rst = 0; req_valid = 0; out_ready = 1;
        chk("reset req_ready", 0, rdy[0], 1);
        chk("reset out_valid", 0, ov[0], 0);
        chk("reset out_data", 0, od[0], 0);
        chk("reset flip_cnt", 0, fc0, 0);

        // plain read
        dir_en = 1; dir_w = 16'h0F0F; dir_f = 4'b0000; req_addr = 8'h05; req_valid = 1;
        tick(); req_valid = 0; req_addr = 8'($urandom);
        chk("plain rd_en T+1", 0, rd_en[0], 1);
        chk("plain addr T+1", 0, maddr[0], 8'h05);
        tick(); chk("plain rd_en T+2", 0, rd_en[0], 0);
        tick();
        chk("plain valid T+3", 0, ov[0], 1);
        chk("plain data", 0, od[0], 16'h0F0F);
        chk("plain flip", 0, of[0], 4'b0000);
        tick();
        chk("plain valid drop", 0, ov[0], 0);
        chk("plain flip_cnt", 0, fc0, 0);
        repeat (4) tick();

        // flipped read
        dir_w = 16'hF0A5; dir_f = 4'b1001; req_valid = 1;
        tick(); req_valid = 0;
        tick(); tick();
        chk("flipped data", 0, od[0], 16'h00AA);
        chk("flipped flip", 0, of[0], 4'b1001);
        tick();
        chk("flipped flip_cnt", 0, fc0, 1);
        repeat (4) tick();

        // backpressure with a live, changing request
        dir_w = 16'h1234; dir_f = 4'b0010; req_addr = 8'h10; req_valid = 1; out_ready = 0;
        repeat (3) begin tick(); req_addr = 8'($urandom); end
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 0, ov[0], 1);
            chk("bp data", 0, od[0], 16'h12C4);
            chk("bp flip", 0, of[0], 4'b0010);
            chk("bp req_ready", 0, rdy[0], 0);
            chk("bp rd_en", 0, rd_en[0], 0);
            req_addr = 8'($urandom);
            tick();
        end
        out_ready = 1;
        tick();
        chk("bp release valid", 0, ov[0], 0);
        chk("bp release ready", 0, rdy[0], 1);
        chk("bp flip_cnt", 0, fc0, 2);
        req_valid = 0;
        repeat (8) tick();

        // reset during the wait/capture cycle
        dir_w = 16'hFFFF; dir_f = 4'b1111; req_valid = 1;
        tick(); req_valid = 0;
        tick(); rst = 1;
        tick(); rst = 0;
        chk("midrst ready", 0, rdy[0], 1);
        chk("midrst valid", 0, ov[0], 0);
        tick();
        chk("midrst valid2", 0, ov[0], 0);
        chk("midrst flip_cnt", 0, fc0, 0);

        // throughput and saturation on the 2-bit counter instance
        dir_w = 16'($urandom); dir_f = 4'b0110; req_valid = 1; out_ready = 1;
        accq.delete(); cntq.delete(); rec_en = 1;
        repeat (27) tick();
        req_valid = 0;
        repeat (10) tick();
        rec_en = 0;
        chk("sat acceptances", 1, accq.size(), 5);
        for (int i = 1; i < accq.size(); i++)
            chk("sat spacing", 1, accq[i] - accq[i-1], 6);
        chk("sat handshakes", 1, cntq.size(), 5);
        for (int i = 0; i < cntq.size() && i < 5; i++)
            chk("sat flip_cnt seq", 1, cntq[i], sat_exp[i]);

        // random traffic
        dir_en = 0;
        repeat (2000) begin
            rst       = ($urandom_range(63) == 0);
            req_valid = ($urandom_range(2) != 0);
            out_ready = ($urandom_range(3) != 0);
            req_addr  = 8'($urandom);
            tick();
        end
        rst = 0; req_valid = 0; out_ready = 1;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flip_read_decoder.md
Name: flip_read_decoder

Overview:
Read-side counterpart of the flip (write) path in the flipping mechanism. It accepts a read request and issues one read to the fault-prone storage. It captures the returned data word plus its per-segment flip flags, then re-inverts every flagged segment to recover the original data. The restored word is presented on a valid/ready output, and the block keeps a saturating count of words that arrived flipped.

Parameters:
N, 16, data word width in bits.
FLIP_W, 4, number of flip segments (one flip flag per segment); N must be divisible by FLIP_W; segment width SW = N/FLIP_W.
ADDR_W, 8, address width.
MEM_LAT, 1, storage read latency in cycles (>=1).
CNT_W, 16, width of the flipped-word counter.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  read request valid.
req_ready  output  1  request accepted when req_valid && req_ready.
req_addr  input  ADDR_W  read address, sampled only on acceptance.
mem_rd_en  output  1  one-cycle read strobe to storage (registered).
mem_addr  output  ADDR_W  read address to storage (registered).
mem_rdata  input  N  stored (possibly flipped) data.
mem_flip  input  FLIP_W  stored flip flags, bit s covers segment s.
out_valid  output  1  restored word valid.
out_ready  input  1  consumer ready.
out_data  output  N  restored data.
out_flip  output  FLIP_W  flip flags captured with out_data.
flip_cnt  output  CNT_W  saturating count of delivered words with any flip flag set.

Behaviour:
- Reset values: state IDLE, mem_rd_en 0, mem_addr 0, out_valid 0, out_data 0, out_flip 0, flip_cnt 0. Because req_ready is derived from state, it reads 1 in IDLE.
- FSM states: IDLE, ISSUE, WAIT, HOLD. Only one read is outstanding at a time.
- req_ready = (state == IDLE), driven combinationally from state only.
- IDLE: on req_valid, latch req_addr into mem_addr and go to ISSUE.
- ISSUE: mem_rd_en = 1 for exactly this cycle, with mem_addr stable. Load the latency counter with MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. mem_rdata and mem_flip are valid in the cycle that is MEM_LAT cycles after the ISSUE cycle. Sample them at the end of that cycle, load the outputs, and go to HOLD.
- Decode rule: out_data[s*SW +: SW] = mem_rdata[s*SW +: SW] ^ {SW{mem_flip[s]}} for s = 0..FLIP_W-1; out_flip = mem_flip.
- HOLD: out_valid = 1. out_data and out_flip stay stable while out_ready = 0. On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: with acceptance in cycle T, out_valid first rises in cycle T+2+MEM_LAT.
- Back-to-back requests (req_valid and out_ready held high): one acceptance every MEM_LAT+3 cycles.
- flip_cnt increments by 1 on each output handshake where |out_flip = 1. It saturates at 2^CNT_W-1 and never wraps.
- In ISSUE, WAIT and HOLD, req_valid is ignored and req_addr is not sampled.
- mem_rdata and mem_flip are ignored outside the capture cycle.
- rst in any state forces the reset values on the next edge. Any in-flight memory response is discarded, and no out_valid is produced for an aborted request.
- out_ready while out_valid = 0 has no effect.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, req_ready = 1, mem_rd_en never asserted.
- Plain read (N=16, FLIP_W=4, MEM_LAT=1): accept addr 0x05 at T, memory returns 0x0F0F with flags 4'b0000 -> mem_rd_en = 1 and mem_addr = 0x05 only in T+1; out_valid in T+3; out_data = 0x0F0F, out_flip = 0, flip_cnt stays 0.
- Flipped read: memory returns 0xF0A5 with flags 4'b1001 -> out_data = 0x00AA, out_flip = 4'b1001, flip_cnt = 1 after the handshake.
- Backpressure: out_ready = 0 for 5 cycles while req_valid = 1 with a changing address -> out_valid, out_data and out_flip stable, req_ready = 0, no new mem_rd_en. Then out_ready = 1 -> one handshake and return to IDLE.
- Reset mid-operation: assert rst in WAIT while the memory drives 0xFFFF with flags 4'b1111 -> IDLE next cycle, out_valid stays 0, flip_cnt stays 0.
- Saturation and throughput: CNT_W=2, MEM_LAT=3, 5 back-to-back flipped reads with out_ready = 1 -> acceptances spaced 6 cycles apart, flip_cnt sequence 1, 2, 3, 3, 3.
